// File: rtl/cpu_bus_pkg.sv
// Shared types for the 65C02 bus fabric: FSM state, region index with an
// UNMAPPED sentinel, and the wait-state counter width.
package cpu_bus_pkg;

   localparam int CNT_W = 4;
   localparam int IDX_W = 5;

   typedef logic [IDX_W-1:0] region_idx_t;

   localparam region_idx_t      IDX_UNMAPPED = 5'd16;
   localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } bus_state_t;

endpackage

// File: rtl/cpu_bus_decode.sv
// Combinational address decode: per-window 17-bit range compare, lowest-index
// priority, one-hot hit and window-relative offset.
module cpu_bus_decode
   import cpu_bus_pkg::*;
#(
   parameter int                          NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*16-1:0]   REGION_BASE = {16'hA000, 16'h9000, 16'h8000, 16'h0000},
   parameter logic [NUM_REGIONS*17-1:0]   REGION_SIZE = {17'h00400, 17'h01000, 17'h01000, 17'h08000}
) (
   input  logic [15:0]             addr,
   output logic [NUM_REGIONS-1:0]  hit,
   output region_idx_t             idx,
   output logic [15:0]             offset
);

   logic [NUM_REGIONS-1:0] raw_hit_s;

   for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cmp
      localparam logic [16:0] BASE  = {1'b0, REGION_BASE[g*16 +: 16]};
      localparam logic [16:0] LIMIT = BASE + REGION_SIZE[g*17 +: 17];
      assign raw_hit_s[g] = ({1'b0, addr} >= BASE) && ({1'b0, addr} < LIMIT);
      assign hit[g]       = (idx == region_idx_t'(g));
   end

   // Scan high to low so the lowest matching index is the one left standing
   always_comb begin
      idx    = IDX_UNMAPPED;
      offset = 16'h0000;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         idx    = raw_hit_s[i] ? region_idx_t'(i) : idx;
         offset = raw_hit_s[i] ? (addr - REGION_BASE[i*16 +: 16]) : offset;
      end
   end

endmodule

// File: rtl/cpu_bus_fabric.sv
// 65C02 bus fabric: window decode, chip selects, RDY wait-state insertion and
// registered read-data select. Define BUS_ERR_EN to enable unmapped-access logging.
module cpu_bus_fabric
   import cpu_bus_pkg::*;
#(
   parameter int                          NUM_REGIONS   = 4,
   parameter logic [NUM_REGIONS*16-1:0]   REGION_BASE   = {16'hA000, 16'h9000, 16'h8000, 16'h0000},
   parameter logic [NUM_REGIONS*17-1:0]   REGION_SIZE   = {17'h00400, 17'h01000, 17'h01000, 17'h08000},
   parameter logic [NUM_REGIONS*4-1:0]    REGION_WAIT   = {4'd2, 4'd0, 4'd0, 4'd0},
   parameter logic [7:0]                  UNMAPPED_DATA = 8'hEA
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [15:0]              cpu_ab,
   input  logic                     cpu_we,
   input  logic [7:0]               cpu_do,
   output logic [7:0]               cpu_di,
   output logic                     cpu_rdy,
   output logic [NUM_REGIONS-1:0]   region_cs,
   output logic                     region_we,
   output logic [15:0]              region_addr,
   output logic [7:0]               region_wdata,
   input  logic [NUM_REGIONS*8-1:0] region_rdata,
   input  logic                     err_clr,
   output logic                     err_flag,
   output logic [15:0]              err_addr,
   output logic [7:0]               err_count
);

   logic [NUM_REGIONS-1:0] dec_hit_s;
   region_idx_t            dec_idx_s;
   logic [15:0]            dec_offset_s;

   cpu_bus_decode #(
      .NUM_REGIONS (NUM_REGIONS),
      .REGION_BASE (REGION_BASE),
      .REGION_SIZE (REGION_SIZE)
   ) u_decode (
      .addr   (cpu_ab),
      .hit    (dec_hit_s),
      .idx    (dec_idx_s),
      .offset (dec_offset_s)
   );

   bus_state_t             state_r, state_nxt_s;
   logic [CNT_W-1:0]       cnt_r, cnt_nxt_s, dec_wait_s;
   region_idx_t            lat_idx_r, sel_r, done_idx_s;
   logic                   done_s, rdy_s, we_s;
   logic [NUM_REGIONS-1:0] lat_hit_s, cs_s;
   logic [15:0]            lat_base_s;

   // Parameter lookups by runtime index, plus the registered read-data mux
   always_comb begin
      dec_wait_s = '0;
      lat_base_s = 16'h0000;
      lat_hit_s  = '0;
      cpu_di     = UNMAPPED_DATA;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         dec_wait_s   = (dec_idx_s == region_idx_t'(i)) ? REGION_WAIT[i*4 +: 4] : dec_wait_s;
         lat_base_s   = (lat_idx_r == region_idx_t'(i)) ? REGION_BASE[i*16 +: 16] : lat_base_s;
         lat_hit_s[i] = (lat_idx_r == region_idx_t'(i));
         cpu_di       = (sel_r == region_idx_t'(i)) ? region_rdata[i*8 +: 8] : cpu_di;
      end
   end

   // Access sequencing: zero-wait and unmapped accesses finish in IDLE, slow ones stall in WAIT
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      done_s      = 1'b0;
      done_idx_s  = dec_idx_s;
      cs_s        = '0;
      we_s        = 1'b0;
      rdy_s       = 1'b1;
      region_addr = dec_offset_s;
      case (state_r)
         ST_IDLE: begin
            cs_s = dec_hit_s;
            if (dec_wait_s == '0) begin
               done_s = 1'b1;
               we_s   = cpu_we && (|dec_hit_s);
            end else begin
               rdy_s       = 1'b0;
               cnt_nxt_s   = dec_wait_s;
               state_nxt_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cs_s        = lat_hit_s;
            region_addr = cpu_ab - lat_base_s;
            done_idx_s  = lat_idx_r;
            cnt_nxt_s   = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               done_s      = 1'b1;
               we_s        = cpu_we;
               state_nxt_s = ST_IDLE;
            end else begin
               rdy_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   assign region_cs    = rst ? '0   : cs_s;
   assign region_we    = rst ? 1'b0 : we_s;
   assign cpu_rdy      = rst ? 1'b1 : rdy_s;
   assign region_wdata = cpu_do;

   // FSM state, wait counter, latched window and read-data select
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         lat_idx_r <= IDX_UNMAPPED;
         sel_r     <= IDX_UNMAPPED;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         lat_idx_r <= (state_r == ST_IDLE) ? dec_idx_s : lat_idx_r;
         sel_r     <= done_s ? done_idx_s : sel_r;
      end
   end

`ifdef BUS_ERR_EN
   logic unmapped_done_s;
   assign unmapped_done_s = (state_r == ST_IDLE) && (dec_idx_s == IDX_UNMAPPED);

   // Sticky error log; an unmapped access in the clear cycle restarts the log
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_flag  <= 1'b0;
         err_addr  <= 16'h0000;
         err_count <= 8'h00;
      end else if (unmapped_done_s) begin
         err_flag  <= 1'b1;
         err_addr  <= (err_flag && !err_clr) ? err_addr : cpu_ab;
         err_count <= err_clr ? 8'h01 : ((err_count == 8'hFF) ? 8'hFF : err_count + 8'h01);
      end else if (err_clr) begin
         err_flag  <= 1'b0;
         err_addr  <= 16'h0000;
         err_count <= 8'h00;
      end else begin
         err_flag  <= err_flag;
         err_addr  <= err_addr;
         err_count <= err_count;
      end
   end
`else
   logic unused_err_clr_s;
   assign unused_err_clr_s = err_clr;
   assign err_flag         = 1'b0;
   assign err_addr         = 16'h0000;
   assign err_count        = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_bus_fabric.sv
// Randomized self-checking bench for cpu_bus_fabric against a transaction-level
// model of the window map, wait states, read select and error log.
module tb_cpu_bus_fabric;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpu_ab;
   logic        cpu_we;
   logic [7:0]  cpu_do;
   logic [7:0]  cpu_di;
   logic        cpu_rdy;
   logic [3:0]  region_cs;
   logic        region_we;
   logic [15:0] region_addr;
   logic [7:0]  region_wdata;
   logic [31:0] region_rdata;
   logic        err_clr;
   logic        err_flag;
   logic [15:0] err_addr;
   logic [7:0]  err_count;

   logic [7:0]  ovl_di;
   logic        ovl_rdy;
   logic [1:0]  ovl_cs;
   logic        ovl_we;
   logic [15:0] ovl_addr;
   logic [7:0]  ovl_wdata;
   logic        ovl_flag;
   logic [15:0] ovl_eaddr;
   logic [7:0]  ovl_ecount;

   cpu_bus_fabric u_dut (
      .clk(clk), .rst(rst), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
      .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .region_cs(region_cs), .region_we(region_we),
      .region_addr(region_addr), .region_wdata(region_wdata), .region_rdata(region_rdata),
      .err_clr(err_clr), .err_flag(err_flag), .err_addr(err_addr), .err_count(err_count)
   );

   // Window 0 spans the whole 64 KiB space and overlaps window 1 at 0x8000
   cpu_bus_fabric #(
      .NUM_REGIONS (2),
      .REGION_BASE ({16'h8000, 16'h0000}),
      .REGION_SIZE ({17'h01000, 17'h10000}),
      .REGION_WAIT ({4'd0, 4'd0})
   ) u_ovl (
      .clk(clk), .rst(rst), .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do),
      .cpu_di(ovl_di), .cpu_rdy(ovl_rdy), .region_cs(ovl_cs), .region_we(ovl_we),
      .region_addr(ovl_addr), .region_wdata(ovl_wdata), .region_rdata(region_rdata[15:0]),
      .err_clr(err_clr), .err_flag(ovl_flag), .err_addr(ovl_eaddr), .err_count(ovl_ecount)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   int base_m[4] = '{32'h0000, 32'h8000, 32'h9000, 32'hA000};
   int size_m[4] = '{32'h8000, 32'h1000, 32'h1000, 32'h0400};
   int wait_m[4] = '{0, 0, 0, 2};

   int prev_sel;
   bit m_flag;
   int m_addr;
   int m_count;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int find_region(input int a);
      for (int i = 0; i < 4; i++) begin
         if (a >= base_m[i] && a < base_m[i] + size_m[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      prev_sel = -1;
      m_flag   = 1'b0;
      m_addr   = 0;
      m_count  = 0;
   endtask

   // One CPU access, from address presentation through its completion cycle
   task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d, input logic clr);
      int         r;
      int         wt;
      logic [3:0] cs_exp;
      logic [7:0] di_exp;
      r  = find_region(int'(a));
      wt = (r < 0) ? 0 : wait_m[r];
      cs_exp = 4'b0000;
      if (r >= 0) cs_exp[r] = 1'b1;
      cpu_ab  = a;
      cpu_we  = w;
      cpu_do  = d;
      err_clr = clr;
      for (int c = 0; c <= wt; c++) begin
         region_rdata = $urandom;
         @(negedge clk);
         if (c == 0) begin
            di_exp = (prev_sel < 0) ? 8'hEA : region_rdata[prev_sel*8 +: 8];
            check_eq("cpu_di", 32'(cpu_di), 32'(di_exp));
            check_eq("err_flag", 32'(err_flag), 32'(m_flag));
            check_eq("err_addr", 32'(err_addr), m_addr);
            check_eq("err_count", 32'(err_count), m_count);
         end
         check_eq("cpu_rdy", 32'(cpu_rdy), 32'(c == wt));
         check_eq("region_cs", 32'(region_cs), 32'(cs_exp));
         check_eq("region_we", 32'(region_we), 32'((c == wt) && w && (r >= 0)));
         check_eq("region_wdata", 32'(region_wdata), 32'(d));
         if (r >= 0) check_eq("region_addr", 32'(region_addr), int'(a) - base_m[r]);
         @(posedge clk);
         #1;
         err_clr = 1'b0;
      end
`ifdef BUS_ERR_EN
      if (r < 0) begin
         if (!m_flag || clr) m_addr = int'(a);
         m_count = clr ? 1 : ((m_count < 255) ? m_count + 1 : 255);
         m_flag  = 1'b1;
      end else if (clr) begin
         m_flag  = 1'b0;
         m_addr  = 0;
         m_count = 0;
      end
`endif
      prev_sel = r;
   endtask

   initial begin
      logic [15:0] a;
      int          k;
      rst          = 1'b1;
      cpu_ab       = 16'hA000;
      cpu_we       = 1'b1;
      cpu_do       = 8'h00;
      err_clr      = 1'b0;
      region_rdata = $urandom;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rdy", 32'(cpu_rdy), 32'd1);
      check_eq("rst_cs", 32'(region_cs), 32'd0);
      check_eq("rst_we", 32'(region_we), 32'd0);
      check_eq("rst_di", 32'(cpu_di), 32'hEA);
      check_eq("rst_err", {15'd0, err_flag, err_addr}, 32'd0);
      check_eq("rst_cnt", 32'(err_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      access(16'h1234, 1'b0, 8'h00, 1'b0);
      access(16'hA003, 1'b1, 8'h77, 1'b0);
      access(16'hF000, 1'b0, 8'h00, 1'b0);
      access(16'h8000, 1'b0, 8'h00, 1'b0);
      check_eq("ovl_cs", 32'(ovl_cs), 32'd1);
      check_eq("ovl_addr", 32'(ovl_addr), 32'h8000);
      check_eq("main_cs_8000", 32'(region_cs), 32'd2);

      for (int n = 0; n < 500; n++) begin
         k = $urandom_range(0, 3);
         case ($urandom_range(0, 6))
            0, 1, 2: a = 16'(base_m[k] + $urandom_range(0, size_m[k] - 1));
            3:       a = 16'(base_m[k] + size_m[k]);
            4:       a = 16'(base_m[k] + size_m[k] - 1);
            5:       a = 16'(base_m[k] - 1);
            default: a = 16'($urandom_range(0, 65535));
         endcase
         access(a, 1'($urandom), 8'($urandom), $urandom_range(0, 15) == 0);
      end

      access(16'h0000, 1'b0, 8'h00, 1'b1);
      for (int n = 0; n < 300; n++) begin
         access(16'($urandom_range(32'hA400, 32'hFFFF)), 1'($urandom), 8'($urandom), 1'b0);
      end
`ifdef BUS_ERR_EN
      check_eq("err_sat", 32'(err_count), 32'd255);
`else
      check_eq("err_tied", 32'(err_count), 32'd0);
`endif
      access(16'hF123, 1'b0, 8'h00, 1'b1);
      access(16'h0010, 1'b0, 8'h00, 1'b0);

      // Reset during the first wait cycle of a slow write
      cpu_ab       = 16'hA000;
      cpu_we       = 1'b1;
      cpu_do       = 8'h55;
      region_rdata = $urandom;
      @(negedge clk);
      check_eq("mw_rdy", 32'(cpu_rdy), 32'd0);
      check_eq("mw_cs", 32'(region_cs), 32'h8);
      check_eq("mw_we", 32'(region_we), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check_eq("mw_rst_rdy", 32'(cpu_rdy), 32'd1);
      check_eq("mw_rst_cs", 32'(region_cs), 32'd0);
      check_eq("mw_rst_we", 32'(region_we), 32'd0);
      @(posedge clk);
      #1;
      check_eq("mw_rst_we2", 32'(region_we), 32'd0);
      check_eq("mw_rst_di", 32'(cpu_di), 32'hEA);
      check_eq("mw_rst_err", {15'd0, err_flag, err_addr}, 32'd0);
      rst = 1'b0;
      model_reset();
      access(16'h0000, 1'b0, 8'h00, 1'b0);
      access(16'hA3FF, 1'b0, 8'h00, 1'b0);
      access(16'h9000, 1'b0, 8'h00, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_bus_fabric.md
# cpu_bus_fabric

Parametrised 65C02 bus fabric that replaces hand-written address compares and per-region read muxing. Decodes the CPU address into NUM_REGIONS windows and drives one chip select per window. Registers the read-data select and inserts per-region wait states through RDY, so slow units (QOI accelerator, external memory) can sit on the same bus as zero-wait RAM/ROM. Sits directly between cpu_65c02 and all memories/peripherals.

## Interface
- NUM_REGIONS, 4, number of decoded windows (1..16)
- REGION_BASE, {16'h0000,16'h8000,16'h9000,16'hA000}, packed NUM_REGIONS×16, window start; index 0 in LSBs
- REGION_SIZE, {16'h8000,16'h1000,16'h1000,16'h0400}, packed NUM_REGIONS×17, window length in bytes (17 bits so 64 KiB is expressible)
- REGION_WAIT, {4'd0,4'd0,4'd0,4'd2}, packed NUM_REGIONS×4, wait states per window (0..15)
- UNMAPPED_DATA, 8'hEA, read data for unmapped addresses
- clk  in  1  single clock
- rst  in  1  reset, asynchronous, active-high
- cpu_ab  in  16  CPU address
- cpu_we  in  1  CPU write enable
- cpu_do  in  8  CPU write data
- cpu_di  out  8  read data to CPU
- cpu_rdy  out  1  RDY to CPU
- region_cs  out  NUM_REGIONS  one-hot chip selects
- region_we  out  1  write strobe, qualified by region_cs
- region_addr  out  16  cpu_ab − base of selected window
- region_wdata  out  8  cpu_do passthrough
- region_rdata  in  NUM_REGIONS×8  per-window read data, registered by the target
- err_clr  in  1  clears error state (BUS_ERR_EN)
- err_flag  out  1  sticky unmapped-access flag
- err_addr  out  16  address of first unmapped access
- err_count  out  8  saturating unmapped-access count

## Operation
- Hit for window i: REGION_BASE[i] ≤ cpu_ab < REGION_BASE[i]+REGION_SIZE[i]. Compare is 17-bit. Lowest index wins on overlap. No hit means unmapped.
- States: IDLE, WAIT.
- IDLE, hit i, REGION_WAIT[i]=0: access completes this cycle. region_cs[i]=1. region_we=cpu_we. cpu_rdy=1.
- IDLE, hit i, REGION_WAIT[i]=W>0: load cnt=W. Go to WAIT. cpu_rdy=0. region_cs[i]=1. region_we=0.
- WAIT: region_cs held on the latched index. cnt decrements each cycle. cpu_rdy=0 while cnt≠1. When cnt=1, cpu_rdy=1 and region_we=cpu_we; this is the completion cycle, then return to IDLE. Total stall is exactly W cycles; a write strobes once.
- While cpu_rdy=0, the CPU holds cpu_ab, cpu_we and cpu_do. The latched index is used regardless of cpu_ab.
- Unmapped: completes immediately. region_cs=0. Writes are dropped.
- Read select: sel_q <= completing index (or UNMAPPED sentinel) on each completion cycle. cpu_di = region_rdata[sel_q], or UNMAPPED_DATA if sel_q is unmapped. Targets must present rdata on the cycle after completion.

## Timing
- Zero-wait read latency: address in cycle T, cpu_di valid in T+1, matching synchronous RAM.
- W-wait read: address in T, cpu_rdy low T..T+W−1, completion at T+W, cpu_di valid at T+W+1.
- Back-to-back accesses in different windows need no idle cycle.
- While rst is high: state=IDLE, cnt=0, sel_q=UNMAPPED, cpu_rdy=1, region_cs=0, region_we=0, cpu_di=UNMAPPED_DATA, err_flag=0, err_addr=0, err_count=0.
- Reset asserted mid-WAIT aborts the access. No write is issued.

## Configuration
- BUS_ERR_EN defined: every unmapped completion sets err_flag. The first one, while err_flag=0, captures err_addr. err_count increments and saturates at 255.
- With BUS_ERR_EN, err_clr zeroes all three next cycle. If err_clr and an unmapped access occur in the same cycle, the access wins: flag=1, count=1, addr captured.
- BUS_ERR_EN undefined: ports remain, err_flag, err_addr and err_count are tied 0, and err_clr is ignored.

## Structure
- Package cpu_bus_pkg holds: the state enum, the region index type sized for 16 regions plus the UNMAPPED sentinel, and the wait-count width constant.
- Sub-module cpu_bus_decode: combinational one-hot hit, priority index and offset generation from the parameters.

## Test plan
- Read 0x1234 with RAM rdata=0x5A → region_cs=0001, region_addr=0x1234, cpu_rdy stays 1, cpu_di=0x5A next cycle.
- Write 0xA003=0x77 (W=2) → cpu_rdy low 2 cycles, region_cs=1000 for 3 cycles, region_we high only on the 3rd, region_addr=0x0003.
- Read 0xF000 (unmapped) → region_cs=0, cpu_di=0xEA; with BUS_ERR_EN, err_flag=1, err_addr=0xF000, err_count=1.
- 300 unmapped reads, then err_clr pulsed alongside one more unmapped read → err_count saturates at 255, then reads flag=1/count=1.
- Overlapping windows 0 and 1 both covering 0x8000 → region_cs=0001 only.
- rst asserted during the first wait cycle of an 0xA000 write → region_we never high, cpu_rdy=1, region_cs=0, state returns to IDLE.
